// File: rtl/ws2812_pkg.sv
// Shared FSM state type, default WS2812 timing constants and the brightness scale helper.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_SHIFT,
    ST_LATCH
  } state_t;

  localparam int unsigned DEF_MAX_LEDS = 256;
  localparam int unsigned DEF_ADDR_W   = 10;
  localparam int unsigned DEF_RD_LAT   = 1;
  localparam int unsigned DEF_T0H_CYC  = 20;
  localparam int unsigned DEF_T1H_CYC  = 40;
  localparam int unsigned DEF_TBIT_CYC = 62;
  localparam int unsigned DEF_TRST_CYC = 15000;
  localparam int unsigned PIX_BITS     = 24;

  // (byte * (brightness + 1)) >> 8; 255 is a pass-through, 0 blanks the byte.
  function automatic logic [7:0] scale_byte(input logic [7:0] d, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, d} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction

endpackage

// File: rtl/ws2812_cell_gen.sv
// Single NRZ cell generator: accepts one bit per cell and drives the registered serial line.
module ws2812_cell_gen
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H_CYC  = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC  = DEF_T1H_CYC,
  parameter int unsigned TBIT_CYC = DEF_TBIT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic bit_valid,
  output logic bit_ready,
  output logic ser_data
);
  localparam int unsigned CNT_W = $clog2(TBIT_CYC + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_cyc;
  logic             active;
  logic             last;

  // Ready in the final cycle of a cell lets the next bit start with no idle cycle.
  always_comb begin
    last      = (cnt == CNT_W'(TBIT_CYC - 1));
    bit_ready = !active || last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      cnt      <= '0;
      high_cyc <= '0;
      ser_data <= 1'b0;
    end else if (bit_valid && bit_ready) begin
      active   <= 1'b1;
      cnt      <= '0;
      high_cyc <= bit_in ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
      ser_data <= 1'b1;
    end else if (active) begin
      cnt      <= cnt + CNT_W'(1);
      ser_data <= ((cnt + CNT_W'(1)) < high_cyc);
      if (last) begin
        active   <= 1'b0;
        ser_data <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ws2812_stream_driver.sv
// WS2812 chain driver: fetches G,R,B bytes from frame RAM, scales them by brightness and
// streams them through the cell generator, prefetching the next pixel while shifting.
module ws2812_stream_driver
  import ws2812_pkg::*;
#(
  parameter int unsigned MAX_LEDS = DEF_MAX_LEDS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned RD_LAT   = DEF_RD_LAT,
  parameter int unsigned T0H_CYC  = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC  = DEF_T1H_CYC,
  parameter int unsigned TBIT_CYC = DEF_TBIT_CYC,
  parameter int unsigned TRST_CYC = DEF_TRST_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        led_count,
  input  logic [7:0]        brightness,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              ser_data
);
  localparam int unsigned LAT_W = $clog2(TRST_CYC + 1);

  state_t            state, state_d;
  logic [8:0]        n_q, n_clamp, fetch_pix, shift_pix;
  logic [7:0]        bright_q;
  logic [1:0]        iss_left, cap_k;
  logic              fetch_busy, buf_full, sr_valid;
  logic [23:0]       buf_q, sr;
  logic [4:0]        bit_cnt;
  logic [RD_LAT-1:0] rd_pipe;
  logic [LAT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] pix_addr;
  logic              cg_ready, cg_valid, accept, pix_end, start_ok;
  logic              fetch_go, cap, load, latch_end;

  always_comb begin
    n_clamp   = (led_count > 9'(MAX_LEDS)) ? 9'(MAX_LEDS) : led_count;
    start_ok  = (state == ST_IDLE) && start && !done;
    cg_valid  = (state == ST_SHIFT) && sr_valid;
    accept    = cg_valid && cg_ready;
    pix_end   = accept && (bit_cnt == 5'(PIX_BITS - 1));
    fetch_go  = ((state == ST_PREFETCH) || (state == ST_SHIFT)) &&
                !fetch_busy && !buf_full && (fetch_pix < n_q);
    cap       = rd_pipe[RD_LAT-1];
    // The buffered pixel moves into the shift register at prefetch end or on the last cell accept.
    load      = buf_full && ((state == ST_PREFETCH) ||
                             ((state == ST_SHIFT) && (!sr_valid || pix_end)));
    latch_end = (state == ST_LATCH) && (lat_cnt == LAT_W'(TRST_CYC - 1));
    pix_addr  = ADDR_W'({1'b0, fetch_pix, 1'b0} + {2'b00, fetch_pix});
  end

  always_comb begin
    state_d = state;
    busy    = (state != ST_IDLE);
    case (state)
      ST_IDLE:     if (start_ok) state_d = (n_clamp == 9'd0) ? ST_LATCH : ST_PREFETCH;
      ST_PREFETCH: if (buf_full) state_d = ST_SHIFT;
      ST_SHIFT:    if (!sr_valid && (shift_pix == n_q) && cg_ready) state_d = ST_LATCH;
      ST_LATCH:    if (latch_end) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      done       <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      rd_pipe    <= '0;
      n_q        <= '0;
      bright_q   <= '0;
      fetch_pix  <= '0;
      shift_pix  <= '0;
      iss_left   <= '0;
      cap_k      <= '0;
      fetch_busy <= 1'b0;
      buf_full   <= 1'b0;
      buf_q      <= '0;
      sr         <= '0;
      sr_valid   <= 1'b0;
      bit_cnt    <= '0;
      lat_cnt    <= '0;
    end else begin
      state   <= state_d;
      done    <= latch_end;
      rd_pipe <= RD_LAT'({rd_pipe, mem_rd});
      mem_rd  <= 1'b0;

      if (start_ok) begin
        n_q       <= n_clamp;
        bright_q  <= brightness;
        fetch_pix <= '0;
        shift_pix <= '0;
        lat_cnt   <= '0;
      end

      if (fetch_go) begin
        mem_rd     <= 1'b1;
        mem_addr   <= pix_addr;
        iss_left   <= 2'd2;
        fetch_busy <= 1'b1;
        fetch_pix  <= fetch_pix + 9'd1;
      end else if (iss_left != 2'd0) begin
        mem_rd   <= 1'b1;
        mem_addr <= mem_addr + ADDR_W'(1);
        iss_left <= iss_left - 2'd1;
      end

      if (cap) begin
        buf_q <= {buf_q[15:0], scale_byte(mem_data, bright_q)};
        if (cap_k == 2'd2) begin
          cap_k      <= '0;
          buf_full   <= 1'b1;
          fetch_busy <= 1'b0;
        end else begin
          cap_k <= cap_k + 2'd1;
        end
      end

      if (load) begin
        sr        <= buf_q;
        sr_valid  <= 1'b1;
        buf_full  <= 1'b0;
        shift_pix <= shift_pix + 9'd1;
        bit_cnt   <= '0;
      end else if (pix_end) begin
        sr_valid <= 1'b0;
        bit_cnt  <= '0;
      end else if (accept) begin
        sr      <= {sr[22:0], 1'b0};
        bit_cnt <= bit_cnt + 5'd1;
      end

      if (state == ST_LATCH) lat_cnt <= latch_end ? '0 : lat_cnt + LAT_W'(1);
    end
  end

  ws2812_cell_gen #(
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .TBIT_CYC (TBIT_CYC)
  ) u_cell_gen (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (sr[23]),
    .bit_valid (cg_valid),
    .bit_ready (cg_ready),
    .ser_data  (ser_data)
  );

endmodule

// File: tb/tb_ws2812_stream_driver.sv
// Scoreboard bench: stimulus pushes expected addresses, cells and frames; a negedge monitor checks them.
module tb_ws2812_stream_driver;
  localparam int unsigned MAX_LEDS = 20;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned RD_LAT   = 2;
  localparam int unsigned T0H      = 2;
  localparam int unsigned T1H      = 4;
  localparam int unsigned TBIT     = 6;
  localparam int unsigned TRST     = 40;

  logic              clk, rst, start;
  logic [8:0]        led_count;
  logic [7:0]        brightness;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic              busy, done, ser_data;

  ws2812_stream_driver #(
    .MAX_LEDS (MAX_LEDS),
    .ADDR_W   (ADDR_W),
    .RD_LAT   (RD_LAT),
    .T0H_CYC  (T0H),
    .T1H_CYC  (T1H),
    .TBIT_CYC (TBIT),
    .TRST_CYC (TRST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .led_count  (led_count),
    .brightness (brightness),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .busy       (busy),
    .done       (done),
    .ser_data   (ser_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame RAM model with RD_LAT-cycle read latency.
  logic [7:0]        mem [1024];
  logic [ADDR_W-1:0] rd_q [RD_LAT];
  always @(posedge clk) begin
    rd_q[0] <= mem_addr;
    for (int i = 1; i < RD_LAT; i++) rd_q[i] <= rd_q[i-1];
  end
  assign mem_data = mem[rd_q[RD_LAT-1]];

  int vectors = 0;
  int miscompares = 0;
  int exp_addr[$];
  bit exp_bits[$];
  int exp_frames[$];
  int cells_seen = 0;

  task automatic check(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: derive every read address and every transmitted bit from memory contents.
  task automatic launch(input int lc, input int br);
    int n, v;
    n = (lc > int'(MAX_LEDS)) ? int'(MAX_LEDS) : lc;
    led_count  = 9'(lc);
    brightness = 8'(br);
    start      = 1'b1;
    exp_frames.push_back(n);
    for (int p = 0; p < n; p++)
      for (int k = 0; k < 3; k++) begin
        exp_addr.push_back(3 * p + k);
        v = (int'(mem[3 * p + k]) * (br + 1)) / 256;
        for (int i = 7; i >= 0; i--) exp_bits.push_back(bit'((v >> i) & 1));
      end
    tick();
    start      = 1'b0;
    led_count  = 9'($urandom);
    brightness = 8'($urandom);
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (!done && c < 5000) begin
      tick();
      c++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic finish_frame();
    wait_done();
    tick();
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
  endtask

  // Monitor
  bit prev_ser = 0, prev_busy = 0, prev_done = 0, cur_bit;
  int hi_cnt = 0, lo_cnt = 0, since_rise = 0, frame_cells = 0, busy_cnt = 0;
  int pre = 0, last_hi = 0, fr_n = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ser = 0; prev_busy = 0; prev_done = 0;
        hi_cnt = 0; lo_cnt = 0; since_rise = 0; frame_cells = 0; busy_cnt = 0; pre = 0;
      end else begin
        if (busy && !prev_busy) begin
          frame_cells = 0; busy_cnt = 0; lo_cnt = 0; pre = 0;
        end
        if (prev_done) check("done_width", int'(done), 0);
        if (mem_rd) begin
          if (exp_addr.size() == 0) check("read_unexpected", int'(mem_addr), -1);
          else check("mem_addr", int'(mem_addr), exp_addr.pop_front());
        end
        if (ser_data && !prev_ser) begin
          if (frame_cells == 0) pre = busy_cnt;
          else check("cell_period", since_rise, TBIT);
          since_rise = 0;
          hi_cnt = 0;
        end
        if (!ser_data && prev_ser) begin
          if (exp_bits.size() == 0) check("cell_unexpected", hi_cnt, 0);
          else begin
            cur_bit = exp_bits.pop_front();
            check("cell_high", hi_cnt, cur_bit ? int'(T1H) : int'(T0H));
          end
          last_hi = hi_cnt;
          lo_cnt = 0;
          frame_cells++;
          cells_seen++;
        end
        if (ser_data) hi_cnt++;
        else if (busy) lo_cnt++;
        since_rise++;
        if (busy) busy_cnt++;
        if (done) begin
          if (exp_frames.size() == 0) check("done_unexpected", 1, 0);
          else begin
            fr_n = exp_frames.pop_front();
            check("frame_cells", frame_cells, 24 * fr_n);
            check("bits_left", exp_bits.size(), 0);
            check("latch_low", lo_cnt, (fr_n == 0) ? int'(TRST) : int'(TRST + TBIT) - last_hi);
            check("busy_cycles", busy_cnt, pre + 24 * fr_n * int'(TBIT) + int'(TRST));
            if (fr_n > 0) check("prefetch_len", int'(pre <= int'(RD_LAT) + 8), 1);
          end
        end
        prev_ser = ser_data; prev_busy = busy; prev_done = done;
      end
    end
  end

  int base, c;
  initial begin
    rst = 1'b1; start = 1'b0; led_count = '0; brightness = '0;
    randomize_mem();
    repeat (4) tick();
    check("reset_ser", int'(ser_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_mem_rd", int'(mem_rd), 0);
    check("reset_mem_addr", int'(mem_addr), 0);
    rst = 1'b0;
    tick();

    mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'hA5;
    launch(1, 255); finish_frame();

    randomize_mem();
    launch(4, int'($urandom_range(0, 255))); finish_frame();

    mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'hFF;
    launch(1, 127); finish_frame();
    launch(1, 0);   finish_frame();

    launch(0, 200);   finish_frame();
    randomize_mem();
    launch(300, 255); finish_frame();

    // start while busy, start in the done cycle, then start one cycle later
    launch(3, int'($urandom_range(0, 255)));
    repeat (60) tick();
    start = 1'b1; led_count = 9'd7;
    tick();
    start = 1'b0;
    wait_done();
    start = 1'b1; led_count = 9'd0;
    tick();
    start = 1'b0;
    check("done_cycle_start", int'(busy), 0);
    launch(2, int'($urandom_range(0, 255)));
    check("restart_busy", int'(busy), 1);
    finish_frame();

    // reset during cell 10 of pixel 2, then replay from address 0
    base = cells_seen;
    launch(5, int'($urandom_range(0, 255)));
    c = 0;
    while (cells_seen < base + 58 && c < 5000) begin
      tick();
      c++;
    end
    check("reach_cell_58", int'(cells_seen >= base + 58), 1);
    rst = 1'b1;
    exp_addr.delete(); exp_bits.delete(); exp_frames.delete();
    tick();
    check("midrst_ser", int'(ser_data), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    rst = 1'b0;
    repeat (TRST + 30) tick();
    check("midrst_idle", int'(busy), 0);
    launch(3, int'($urandom_range(0, 255))); finish_frame();

    for (int f = 0; f < 6; f++) begin
      randomize_mem();
      launch(int'($urandom_range(0, 24)), int'($urandom_range(0, 255)));
      finish_frame();
      repeat (int'($urandom_range(0, 3))) tick();
    end

    repeat (20) tick();
    check("queues_drained", exp_addr.size() + exp_bits.size() + exp_frames.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
